// File: rtl/character_anim_scheduler_if.sv
// character_anim_scheduler_if: game-state inputs and pose outputs of the animation scheduler
interface character_anim_scheduler_if;
    logic              frame_tick;
    logic              in_air;
    logic              vel_up;
    logic              charge_active;
    logic              land_event;
    logic              land_hard;
    logic signed [1:0] move_dir;
    logic [2:0]        char_id;
    logic signed [1:0] char_face;
    logic              anim_changed;
    logic              land_busy;
    modport master (
        output frame_tick, in_air, vel_up, charge_active, land_event, land_hard, move_dir,
        input  char_id, char_face, anim_changed, land_busy
    );
    modport slave (
        input  frame_tick, in_air, vel_up, charge_active, land_event, land_hard, move_dir,
        output char_id, char_face, anim_changed, land_busy
    );
endinterface

// File: rtl/character_anim_scheduler.sv
// character_anim_scheduler: picks the character pose and facing once per display frame
module character_anim_scheduler #(
    parameter int IDLE_PERIOD = 30,
    parameter int LAND_HOLD   = 12,
    parameter int DEBOUNCE    = 2
) (
    input logic sys_clk,
    input logic sys_rst,
    character_anim_scheduler_if.slave bus
);
    localparam int IW = IDLE_PERIOD > 1 ? $clog2(IDLE_PERIOD) : 1;
    localparam int HW = LAND_HOLD > 1 ? $clog2(LAND_HOLD) : 1;
    localparam int DW = DEBOUNCE > 1 ? $clog2(DEBOUNCE) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_PERIOD > 1 ? IDLE_PERIOD - 1 : 0);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LAND_HOLD > 1 ? LAND_HOLD - 1 : 0);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE > 1 ? DEBOUNCE - 1 : 0);
    localparam logic [2:0] IDLE_1 = 3'd0, IDLE_2 = 3'd1, CHARGE = 3'd2, JUMP_UP = 3'd3;
    localparam logic [2:0] JUMP_DOWN = 3'd4, FALL = 3'd5, SAFE = 3'd6;

    logic [2:0]    pose_q, pose_d;
    logic [1:0]    face_q, face_d;
    logic          busy_q, busy_d, anim_q, anim_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          db_q, db_d, air_q, air_d, pend_q, pend_d, hard_q, hard_d;
    logic          land_now, hard_now, idle_wrap;

    // state register: reset aborts any hold, flight or pending landing
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pose_q   <= IDLE_1;
            face_q   <= 2'b01;
            busy_q   <= 1'b0;
            anim_q   <= 1'b0;
            hold_q   <= '0;
            idle_q   <= '0;
            db_cnt_q <= '0;
            db_q     <= 1'b0;
            air_q    <= 1'b0;
            pend_q   <= 1'b0;
            hard_q   <= 1'b0;
        end else begin
            pose_q   <= pose_d;
            face_q   <= face_d;
            busy_q   <= busy_d;
            anim_q   <= anim_d;
            hold_q   <= hold_d;
            idle_q   <= idle_d;
            db_cnt_q <= db_cnt_d;
            db_q     <= db_d;
            air_q    <= air_d;
            pend_q   <= pend_d;
            hard_q   <= hard_d;
        end
    end

    // next state: latch landings between frames, debounce vel_up, apply pose rules on each tick
    always_comb begin
        land_now  = pend_q | bus.land_event;
        hard_now  = bus.land_event ? bus.land_hard : hard_q;
        idle_wrap = idle_q >= IDLE_LAST;
        pose_d    = pose_q;
        face_d    = face_q;
        busy_d    = busy_q;
        hold_d    = hold_q;
        idle_d    = idle_q;
        db_d      = db_q;
        air_d     = air_q;
        db_cnt_d  = bus.in_air ? db_cnt_q : '0;
        pend_d    = land_now;
        hard_d    = hard_now;
        if (bus.frame_tick) begin
            pend_d = 1'b0;
            air_d  = bus.in_air;
            hold_d = '0;
            idle_d = '0;
            if (bus.in_air && !air_q) begin
                db_d     = bus.vel_up;
                db_cnt_d = '0;
            end else if (bus.in_air && bus.vel_up != db_q) begin
                db_d     = db_cnt_q >= DB_LAST ? bus.vel_up : db_q;
                db_cnt_d = db_cnt_q >= DB_LAST ? '0 : db_cnt_q + 1'b1;
            end else begin
                db_cnt_d = '0;
            end
            if (land_now) begin
                pose_d = hard_now ? FALL : SAFE;
                hold_d = HOLD_LAST;
            end else if (bus.in_air) begin
                pose_d = db_d ? JUMP_UP : JUMP_DOWN;
            end else if (hold_q != '0 && (pose_q == FALL || (pose_q == SAFE && !bus.charge_active))) begin
                hold_d = hold_q - 1'b1;
            end else if (bus.charge_active) begin
                pose_d = CHARGE;
            end else if (pose_q == IDLE_1 || pose_q == IDLE_2) begin
                pose_d = idle_wrap ? (pose_q == IDLE_1 ? IDLE_2 : IDLE_1) : pose_q;
                idle_d = idle_wrap ? '0 : idle_q + 1'b1;
            end else begin
                pose_d = IDLE_1;
            end
            busy_d = pose_d == FALL || pose_d == SAFE;
            face_d = (pose_d == IDLE_1 || pose_d == IDLE_2 || pose_d == SAFE) && bus.move_dir != 2'sd0
                     ? (bus.move_dir[1] ? 2'b11 : 2'b01) : face_q;
        end
        anim_d = pose_d != pose_q;
    end

    // outputs come straight from registers
    always_comb begin
        bus.char_id      = pose_q;
        bus.char_face    = face_q;
        bus.anim_changed = anim_q;
        bus.land_busy    = busy_q;
    end
endmodule

// File: tb/tb_character_anim_scheduler.sv
// tb_character_anim_scheduler: scenario and randomized checks against a frame-level pose model
module tb_character_anim_scheduler;
    localparam int IP = 30;
    localparam int LH = 12;
    localparam int DB = 2;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int checks = 0;
    int failures = 0;

    int m_pose, m_left, m_idle, m_run;
    bit m_db, m_air, m_pend, m_hard, m_busy, m_chg;
    logic [1:0] m_face;

    character_anim_scheduler_if bus_if ();

    character_anim_scheduler #(.IDLE_PERIOD(IP), .LAND_HOLD(LH), .DEBOUNCE(DB)) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus(bus_if)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic model_reset();
        m_pose = 0; m_left = 0; m_idle = 0; m_run = 0;
        m_db = 0; m_air = 0; m_pend = 0; m_hard = 0; m_busy = 0; m_chg = 0;
        m_face = 2'b01;
    endtask

    task automatic model_step(input bit lev, input bit lh);
        int prev;
        bit pend, hard;
        prev = m_pose;
        pend = m_pend || lev;
        hard = lev ? lh : m_hard;
        m_pend = 0;
        if (bus_if.in_air && !m_air) begin
            m_db = bus_if.vel_up; m_run = 0;
        end else if (bus_if.in_air && bus_if.vel_up != m_db) begin
            m_run++;
            if (m_run >= DB) begin m_db = bus_if.vel_up; m_run = 0; end
        end else m_run = 0;
        m_air = bus_if.in_air;
        if (pend) begin
            m_pose = hard ? 5 : 6; m_left = LH - 1;
        end else if (bus_if.in_air) begin
            m_pose = m_db ? 3 : 4; m_left = 0;
        end else if (m_left > 0 && (prev == 5 || (prev == 6 && !bus_if.charge_active))) begin
            m_left--;
        end else begin
            m_left = 0;
            if (bus_if.charge_active) m_pose = 2;
            else if (prev > 1) begin m_pose = 0; m_idle = 0; end
            else begin
                m_idle++;
                if (m_idle >= IP) begin m_idle = 0; m_pose = 1 - prev; end
            end
        end
        m_busy = m_pose == 5 || m_pose == 6;
        m_chg = m_pose != prev;
        if ((m_pose <= 1 || m_pose == 6) && bus_if.move_dir != 0)
            m_face = bus_if.move_dir < 0 ? 2'b11 : 2'b01;
    endtask

    task automatic frame(input bit lev = 0, input bit lh = 0);
        @(negedge sys_clk);
        bus_if.frame_tick = 1'b1;
        bus_if.land_event = lev;
        if (lev) bus_if.land_hard = lh;
        model_step(lev, lh);
        @(posedge sys_clk);
        #1;
        bus_if.frame_tick = 1'b0;
        bus_if.land_event = 1'b0;
    endtask

    task automatic land_mid(input bit lh);
        @(negedge sys_clk);
        bus_if.land_event = 1'b1;
        bus_if.land_hard = lh;
        m_pend = 1; m_hard = lh;
        @(negedge sys_clk);
        bus_if.land_event = 1'b0;
    endtask

    task automatic test_reset();
        bus_if.frame_tick = 0; bus_if.in_air = 0; bus_if.vel_up = 0; bus_if.charge_active = 0;
        bus_if.land_event = 0; bus_if.land_hard = 0; bus_if.move_dir = 2'sd0;
        sys_rst = 1'b1;
        model_reset();
        repeat (3) @(negedge sys_clk);
        checks++; if (bus_if.char_id !== 3'd0) begin failures++; $display("FAIL reset_id: got %0d want 0", bus_if.char_id); end
        checks++; if (bus_if.char_face !== 2'b01) begin failures++; $display("FAIL reset_face: got %b want 01", bus_if.char_face); end
        checks++; if (bus_if.anim_changed !== 1'b0) begin failures++; $display("FAIL reset_anim: got %b want 0", bus_if.anim_changed); end
        checks++; if (bus_if.land_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus_if.land_busy); end
        sys_rst = 1'b0;
    endtask

    task automatic test_idle_toggle();
        int pulses = 0;
        for (int t = 1; t <= 65; t++) begin
            frame();
            pulses += bus_if.anim_changed;
            checks++;
            if ({bus_if.char_id, bus_if.char_face, bus_if.land_busy, bus_if.anim_changed} !== {m_pose[2:0], m_face, m_busy, m_chg}) begin
                failures++;
                $display("FAIL idle_t%0d: got id=%0d face=%b busy=%b chg=%b want id=%0d face=%b busy=%b chg=%b",
                         t, bus_if.char_id, bus_if.char_face, bus_if.land_busy, bus_if.anim_changed, m_pose, m_face, m_busy, m_chg);
            end
            if (t == 29 || t == 30 || t == 60) begin
                checks++;
                if (bus_if.char_id !== (t == 30 ? 3'd1 : 3'd0)) begin
                    failures++; $display("FAIL idle_point_t%0d: got %0d want %0d", t, bus_if.char_id, t == 30 ? 1 : 0);
                end
            end
        end
        checks++; if (pulses != 2) begin failures++; $display("FAIL idle_pulses: got %0d want 2", pulses); end
    endtask

    task automatic test_jump();
        bus_if.in_air = 1; bus_if.vel_up = 1;
        for (int t = 1; t <= 5; t++) begin
            frame();
            checks++; if (bus_if.char_id !== 3'd3) begin failures++; $display("FAIL jump_up_t%0d: got %0d want 3", t, bus_if.char_id); end
        end
        bus_if.vel_up = 0;
        frame();
        checks++; if (bus_if.char_id !== 3'd3) begin failures++; $display("FAIL jump_fall1: got %0d want 3", bus_if.char_id); end
        frame();
        checks++; if (bus_if.char_id !== 3'd4) begin failures++; $display("FAIL jump_fall2: got %0d want 4", bus_if.char_id); end
        bus_if.vel_up = 1;
        frame();
        bus_if.vel_up = 0;
        for (int t = 1; t <= 4; t++) begin
            frame();
            checks++; if (bus_if.char_id !== 3'd4 || bus_if.anim_changed !== 1'b0) begin
                failures++; $display("FAIL jump_glitch_t%0d: got id=%0d chg=%b want id=4 chg=0", t, bus_if.char_id, bus_if.anim_changed);
            end
        end
        bus_if.in_air = 0;
        frame();
        checks++; if (bus_if.char_id !== 3'd0) begin failures++; $display("FAIL jump_ground: got %0d want 0", bus_if.char_id); end
    endtask

    task automatic test_hard_land();
        land_mid(1);
        bus_if.charge_active = 1;
        for (int t = 1; t <= LH + 1; t++) begin
            frame();
            checks++;
            if ({bus_if.char_id, bus_if.land_busy} !== (t <= LH ? {3'd5, 1'b1} : {3'd2, 1'b0})) begin
                failures++; $display("FAIL hard_land_t%0d: got id=%0d busy=%b want id=%0d busy=%b",
                                     t, bus_if.char_id, bus_if.land_busy, t <= LH ? 5 : 2, t <= LH);
            end
        end
        bus_if.charge_active = 0;
        frame(1, 1);
        checks++; if (bus_if.char_id !== 3'd5) begin failures++; $display("FAIL coincident_land: got %0d want 5", bus_if.char_id); end
        for (int t = 1; t <= LH + 1; t++) begin
            frame();
            checks++;
            if ({bus_if.char_id, bus_if.char_face, bus_if.land_busy, bus_if.anim_changed} !== {m_pose[2:0], m_face, m_busy, m_chg}) begin
                failures++; $display("FAIL coincident_hold_t%0d: got id=%0d busy=%b want id=%0d busy=%b",
                                     t, bus_if.char_id, bus_if.land_busy, m_pose, m_busy);
            end
        end
    endtask

    task automatic test_safe_land();
        land_mid(1);
        land_mid(0);
        for (int t = 1; t <= 3; t++) begin
            frame();
            checks++; if ({bus_if.char_id, bus_if.land_busy} !== {3'd6, 1'b1}) begin
                failures++; $display("FAIL safe_hold_t%0d: got id=%0d busy=%b want id=6 busy=1", t, bus_if.char_id, bus_if.land_busy);
            end
        end
        bus_if.charge_active = 1;
        frame();
        checks++; if ({bus_if.char_id, bus_if.land_busy} !== {3'd2, 1'b0}) begin
            failures++; $display("FAIL safe_interrupt: got id=%0d busy=%b want id=2 busy=0", bus_if.char_id, bus_if.land_busy);
        end
    endtask

    task automatic test_face();
        bus_if.move_dir = -2'sd1;
        for (int t = 1; t <= 2; t++) begin
            frame();
            checks++; if (bus_if.char_face !== 2'b01) begin failures++; $display("FAIL face_charge_t%0d: got %b want 01", t, bus_if.char_face); end
        end
        bus_if.charge_active = 0;
        frame();
        checks++; if ({bus_if.char_id, bus_if.char_face} !== {3'd0, 2'b11}) begin
            failures++; $display("FAIL face_idle: got id=%0d face=%b want id=0 face=11", bus_if.char_id, bus_if.char_face);
        end
    endtask

    task automatic test_reset_mid_hold();
        land_mid(1);
        frame();
        frame();
        land_mid(0);
        @(posedge sys_clk);
        #2;
        sys_rst = 1'b1;
        #1;
        checks++;
        if ({bus_if.char_id, bus_if.char_face, bus_if.land_busy, bus_if.anim_changed} !== {3'd0, 2'b01, 1'b0, 1'b0}) begin
            failures++; $display("FAIL async_reset: got id=%0d face=%b busy=%b chg=%b want id=0 face=01 busy=0 chg=0",
                                 bus_if.char_id, bus_if.char_face, bus_if.land_busy, bus_if.anim_changed);
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        model_reset();
        bus_if.move_dir = 2'sd0;
        frame();
        checks++; if ({bus_if.char_id, bus_if.land_busy} !== {3'd0, 1'b0}) begin
            failures++; $display("FAIL reset_no_pending: got id=%0d busy=%b want id=0 busy=0", bus_if.char_id, bus_if.land_busy);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            bit lev, lh;
            bus_if.in_air = $urandom_range(0, 2) == 0;
            bus_if.vel_up = $urandom_range(0, 1) == 1;
            bus_if.charge_active = $urandom_range(0, 3) == 0;
            bus_if.move_dir = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) land_mid($urandom_range(0, 1) == 1);
            lev = $urandom_range(0, 7) == 0;
            lh = $urandom_range(0, 1) == 1;
            frame(lev, lh);
            checks++;
            if ({bus_if.char_id, bus_if.char_face, bus_if.land_busy, bus_if.anim_changed} !== {m_pose[2:0], m_face, m_busy, m_chg}) begin
                failures++;
                $display("FAIL random_t%0d: got id=%0d face=%b busy=%b chg=%b want id=%0d face=%b busy=%b chg=%b",
                         t, bus_if.char_id, bus_if.char_face, bus_if.land_busy, bus_if.anim_changed, m_pose, m_face, m_busy, m_chg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_toggle();
        test_jump();
        test_hard_land();
        test_safe_land();
        test_face();
        test_reset_mid_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
